// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// channel and the IF/ID presentation channel. The master modport is the fetch
// unit; the slave modport is its environment (memory, redirect source, IF/ID).
interface fetch_pc_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  imem_req_valid_o;
    logic                  imem_req_ready_i;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] imem_rsp_data_i;
    logic                  if_valid_o;
    logic                  if_ready_i;
    logic [DATA_WIDTH-1:0] if_pc_o;
    logic [DATA_WIDTH-1:0] if_instr_o;

    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        output imem_req_valid_o,
        input  imem_req_ready_i,
        output imem_addr_o,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i,
        output if_valid_o,
        input  if_ready_i,
        output if_pc_o,
        output if_instr_o
    );

    modport slave (
        output redirect_i,
        output redirect_pc_i,
        input  imem_req_valid_o,
        output imem_req_ready_i,
        input  imem_addr_o,
        output imem_rsp_valid_i,
        output imem_rsp_data_i,
        input  if_valid_o,
        output if_ready_i,
        input  if_pc_o,
        input  if_instr_o
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner. Issues one instruction-memory read at a time, captures
// the response and presents {pc, instr} to IF/ID. Redirects retarget the PC and
// squash whatever fetch is in flight; a squashed response is drained in DROP.
module fetch_pc_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] redirect_tgt;

    // Word-aligned redirect target (low two address bits are dropped).
    assign redirect_tgt = bus.redirect_pc_i & ALIGN_MASK;

    assign bus.imem_req_valid_o = (state_q == S_REQ) && rst_n;
    assign bus.imem_addr_o      = pc_q;
    assign bus.if_valid_o       = (state_q == S_HOLD);
    assign bus.if_pc_o          = fetch_pc_q;
    assign bus.if_instr_o       = instr_q;

    // Next-state logic: request, wait for response, drain squashed response, present.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        unique case (state_q)
            S_REQ: begin
                if (bus.redirect_i) begin
                    pc_d = redirect_tgt;
                    // An accepted request in the redirect cycle still returns data; drain it.
                    if (bus.imem_req_ready_i) begin
                        state_d = S_DROP;
                    end
                end else if (bus.imem_req_ready_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + PC_STEP;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_rsp_valid_i ? S_REQ : S_DROP;
                end else if (bus.imem_rsp_valid_i) begin
                    instr_d = bus.imem_rsp_data_i;
                    state_d = S_HOLD;
                end
            end
            S_DROP: begin
                if (bus.redirect_i) begin
                    pc_d = redirect_tgt;
                end
                // The squashed response ends the drain even if a redirect coincides.
                if (bus.imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (bus.redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (bus.if_ready_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch unit.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_pc_unit_if #(.DATA_WIDTH(32)) bus ();
    fetch_pc_unit_if #(.DATA_WIDTH(32)) wbus ();

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.redirect_i = 1'b0;  bus.redirect_pc_i = '0;  bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;  bus.imem_rsp_data_i = '0;  bus.if_ready_i = 1'b0;
        wbus.redirect_i = 1'b0; wbus.redirect_pc_i = '0; wbus.imem_req_ready_i = 1'b0;
        wbus.imem_rsp_valid_i = 1'b0; wbus.imem_rsp_data_i = '0; wbus.if_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid_o); end
        n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b expected 0", bus.if_valid_o); end
        n_checks++; if (wbus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wrap_req_valid: got %b expected 0", wbus.imem_req_valid_o); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rel_req_valid: got %b expected 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rel_addr: got %h expected 00000000", bus.imem_addr_o); end
        n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_if_valid: got %b expected 0", bus.if_valid_o); end
    endtask

    task automatic test_wrap();
        n_checks++; if (wbus.imem_req_valid_o !== 1'b1 || wbus.imem_addr_o !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_first_addr: got v=%b a=%h expected v=1 a=fffffffc", wbus.imem_req_valid_o, wbus.imem_addr_o); end
        wbus.imem_req_ready_i = 1'b1;
        tick();
        wbus.imem_req_ready_i = 1'b0;
        wbus.imem_rsp_valid_i = 1'b1; wbus.imem_rsp_data_i = 32'h0000_0013;
        tick();
        wbus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (wbus.if_valid_o !== 1'b1 || wbus.if_pc_o !== 32'hFFFF_FFFC || wbus.if_instr_o !== 32'h13) begin
            n_fail++; $display("FAIL wrap_present: got v=%b pc=%h i=%h expected v=1 pc=fffffffc i=00000013", wbus.if_valid_o, wbus.if_pc_o, wbus.if_instr_o); end
        wbus.if_ready_i = 1'b1;
        tick();
        n_checks++; if (wbus.imem_req_valid_o !== 1'b1 || wbus.imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next_addr: got v=%b a=%h expected v=1 a=00000000", wbus.imem_req_valid_o, wbus.imem_addr_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] instr;
        bus.imem_req_ready_i = 1'b1;
        bus.if_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = 32'hA000_0000 + 32'(k);
            n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'(4 * k)) begin
                n_fail++; $display("FAIL seq_req[%0d]: got v=%b a=%h expected v=1 a=%h", k, bus.imem_req_valid_o, bus.imem_addr_o, 32'(4 * k)); end
            tick();
            n_checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL seq_wait[%0d]: got req=%b ifv=%b expected 0 0", k, bus.imem_req_valid_o, bus.if_valid_o); end
            bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = instr;
            tick();
            bus.imem_rsp_valid_i = 1'b0;
            n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'(4 * k) || bus.if_instr_o !== instr) begin
                n_fail++; $display("FAIL seq_present[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", k, bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, 32'(4 * k), instr); end
            tick();
        end
    endtask

    task automatic test_redirect_wait();
        n_checks++; if (bus.imem_addr_o !== 32'h0000_000C) begin n_fail++; $display("FAIL rw_start_addr: got %h expected 0000000c", bus.imem_addr_o); end
        tick();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0103;
        tick();
        bus.redirect_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rw_drop[%0d]: got req=%b ifv=%b expected 0 0", c, bus.imem_req_valid_o, bus.if_valid_o); end
            if (c == 1) begin bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'hDEAD_BEEF; end
            tick();
        end
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_no_present: got %b expected 0", bus.if_valid_o); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h0000_0100) begin
            n_fail++; $display("FAIL rw_next_addr: got v=%b a=%h expected v=1 a=00000100", bus.imem_req_valid_o, bus.imem_addr_o); end
    endtask

    task automatic test_redirect_handshake();
        bus.imem_req_ready_i = 1'b0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0010;
        tick();
        bus.redirect_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin
            n_fail++; $display("FAIL rh_addr10: got v=%b a=%h expected v=1 a=00000010", bus.imem_req_valid_o, bus.imem_addr_o); end
        bus.imem_req_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0200;
        tick();
        bus.redirect_i = 1'b0; bus.imem_req_ready_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_drop_noreq: got %b expected 0", bus.imem_req_valid_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h5555_5555;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h200 || bus.if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rh_target: got v=%b a=%h ifv=%b expected v=1 a=00000200 ifv=0", bus.imem_req_valid_o, bus.imem_addr_o, bus.if_valid_o); end
        tick();
        n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_no_present: got %b expected 0", bus.if_valid_o); end
    endtask

    task automatic test_hold_stall();
        bus.imem_req_ready_i = 1'b1; bus.if_ready_i = 1'b0;
        tick();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'hCAFE_0001;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) bus.if_ready_i = 1'b1;
            n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h200 || bus.if_instr_o !== 32'hCAFE_0001 || bus.imem_req_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL hold[%0d]: got v=%b pc=%h i=%h req=%b expected v=1 pc=00000200 i=cafe0001 req=0",
                                   c, bus.if_valid_o, bus.if_pc_o, bus.if_instr_o, bus.imem_req_valid_o); end
            tick();
        end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h204 || bus.if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got req=%b a=%h ifv=%b expected req=1 a=00000204 ifv=0", bus.imem_req_valid_o, bus.imem_addr_o, bus.if_valid_o); end
    endtask

    task automatic test_reset_mid();
        bus.imem_req_ready_i = 1'b0; bus.if_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0020;
        tick();
        bus.redirect_i = 1'b0;
        n_checks++; if (bus.imem_addr_o !== 32'h20) begin n_fail++; $display("FAIL rm_addr20: got %h expected 00000020", bus.imem_addr_o); end
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rm_async: got req=%b ifv=%b expected 0 0", bus.imem_req_valid_o, bus.if_valid_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rm_restart: got v=%b a=%h expected v=1 a=00000000", bus.imem_req_valid_o, bus.imem_addr_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'hBAD0_BAD0;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        tick();
        n_checks++; if (bus.if_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rm_stale: got ifv=%b req=%b a=%h expected ifv=0 req=1 a=00000000", bus.if_valid_o, bus.imem_req_valid_o, bus.imem_addr_o); end
    endtask

    // Transaction-level model: architectural next PC, one in-flight fetch that
    // a redirect may kill, and one presented instruction awaiting IF/ID.
    task automatic test_random();
        logic [31:0] m_pc, m_out_pc, m_pres_pc, m_pres_instr, tgt;
        bit m_out, m_live, m_pres, exp_req;
        int mem_cnt;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        m_pc = 32'h0; m_out = 0; m_live = 0; m_pres = 0;
        m_out_pc = '0; m_pres_pc = '0; m_pres_instr = '0;
        mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                bus.imem_rsp_valid_i = (mem_cnt == 0);
            end else begin
                bus.imem_rsp_valid_i = ($urandom_range(0, 9) == 0);
            end
            bus.imem_rsp_data_i  = $urandom;
            bus.redirect_i       = ($urandom_range(0, 9) == 0);
            bus.redirect_pc_i    = $urandom;
            bus.imem_req_ready_i = ($urandom_range(0, 1) == 1);
            bus.if_ready_i       = ($urandom_range(0, 9) < 6);

            exp_req = !m_out && !m_pres;
            n_checks++; if (bus.imem_req_valid_o !== exp_req) begin
                n_fail++; $display("FAIL rnd_req_valid @%0d: got %b expected %b", cyc, bus.imem_req_valid_o, exp_req); end
            if (exp_req) begin
                n_checks++; if (bus.imem_addr_o !== m_pc) begin
                    n_fail++; $display("FAIL rnd_addr @%0d: got %h expected %h", cyc, bus.imem_addr_o, m_pc); end
            end
            n_checks++; if (bus.if_valid_o !== m_pres) begin
                n_fail++; $display("FAIL rnd_if_valid @%0d: got %b expected %b", cyc, bus.if_valid_o, m_pres); end
            if (m_pres) begin
                n_checks++; if (bus.if_pc_o !== m_pres_pc || bus.if_instr_o !== m_pres_instr) begin
                    n_fail++; $display("FAIL rnd_present @%0d: got pc=%h i=%h expected pc=%h i=%h", cyc, bus.if_pc_o, bus.if_instr_o, m_pres_pc, m_pres_instr); end
            end

            tgt = {bus.redirect_pc_i[31:2], 2'b00};
            if (exp_req) begin
                if (bus.imem_req_ready_i) begin
                    m_out = 1; m_live = !bus.redirect_i; m_out_pc = m_pc;
                    mem_cnt = $urandom_range(1, 3);
                end
                m_pc = bus.redirect_i ? tgt : (bus.imem_req_ready_i ? m_pc + 32'd4 : m_pc);
            end else if (m_out) begin
                if (bus.imem_rsp_valid_i) begin
                    m_out = 0;
                    if (m_live && !bus.redirect_i) begin
                        m_pres = 1; m_pres_pc = m_out_pc; m_pres_instr = bus.imem_rsp_data_i;
                    end
                end
                if (bus.redirect_i) begin m_live = 0; m_pc = tgt; end
            end else begin
                if (bus.redirect_i) begin m_pres = 0; m_pc = tgt; end
                else if (bus.if_ready_i) m_pres = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sequential();
        test_redirect_wait();
        test_redirect_handshake();
        test_hold_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC owner and instruction-memory requester.
- Holds the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures the response and presents {pc, instr} to the IF/ID boundary with valid/ready backpressure.
- Sits between the branch/jump redirect source and the IF/ID pipeline register, and performs the PC+4 increment internally.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction (from defines).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_i  input  1  branch/jump/exception redirect strobe.
- redirect_pc_i  input  DATA_WIDTH  redirect target; bits [1:0] ignored, forced to 0.
- imem_req_valid_o  output  1  instruction read request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_addr_o  output  DATA_WIDTH  request address (= pc_q).
- imem_rsp_valid_i  input  1  read data valid (exactly one per accepted request, ≥1 cycle later).
- imem_rsp_data_i  input  DATA_WIDTH  instruction word.
- if_valid_o  output  1  {if_pc_o, if_instr_o} valid toward IF/ID.
- if_ready_i  input  1  IF/ID accepts.
- if_pc_o  output  DATA_WIDTH  PC of presented instruction.
- if_instr_o  output  DATA_WIDTH  presented instruction.

Behaviour:
- Registers: pc_q, fetch_pc_q, instr_q, state ∈ {REQ, WAIT, DROP, HOLD}.
- Reset (async assert, sync release):
  - pc_q = RESET_PC; state = REQ; fetch_pc_q = 0; instr_q = 0.
  - if_valid_o = 0; imem_req_valid_o = 0 while rst_n low.
- Outputs:
  - imem_req_valid_o = (state == REQ) && rst_n; imem_addr_o = pc_q.
  - if_valid_o = (state == HOLD); if_pc_o = fetch_pc_q; if_instr_o = instr_q. Outputs hold stable while if_valid_o && !if_ready_i.
- PC arithmetic: pc_q + 4 modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 32'h0 with no flag.
- REQ:
  - Handshake (valid && ready) without redirect: fetch_pc_q <= pc_q; pc_q <= pc_q + 4; go WAIT.
  - Redirect without handshake: pc_q <= {redirect_pc_i[31:2], 2'b00}; stay REQ.
  - Redirect with handshake in the same cycle: pc_q <= redirect target; go DROP (the accepted request's response is discarded).
  - Otherwise stay REQ; request held stable until accepted.
- WAIT:
  - Response without redirect: instr_q <= imem_rsp_data_i; go HOLD.
  - Redirect, no response: pc_q <= target; go DROP.
  - Redirect and response in the same cycle: response discarded; pc_q <= target; go REQ.
- DROP:
  - No request issued; the next imem_rsp_valid_i is consumed and discarded, then go REQ.
  - A further redirect in DROP updates pc_q and stays DROP.
- HOLD:
  - if_ready_i without redirect: go REQ. The request issues the next cycle, so peak throughput is 1 instruction per 3 cycles with a zero-wait memory.
  - Redirect, with or without if_ready_i: pc_q <= target; go REQ; if_valid_o deasserts next cycle. Downstream flush handles any same-cycle transfer.
- Latency:
  - First request is visible on the first clk edge after rst_n release.
  - Response-to-if_valid_o is 1 cycle (registered).
- Invariants:
  - At most one outstanding imem request.
  - No imem_rsp_valid_i is expected in REQ or HOLD; if one arrives, it is ignored.
- Reset mid-operation: all state returns to reset values immediately; any in-flight response arriving after reset release while in REQ is ignored.

Test Plan:
- Reset release, imem ready=1, 1-cycle response latency, if_ready=1 → addresses 0x0, 0x4, 0x8 issued; if_pc_o/if_instr_o show (0x0, I0), (0x4, I1), (0x8, I2) in order, one transfer per 3 cycles.
- RESET_PC=32'hFFFF_FFFC → first addr 0xFFFF_FFFC, next addr 0x0000_0000.
- Redirect to 0x0000_0103 while in WAIT, response arrives 2 cycles later with 0xDEAD_BEEF → 0xDEAD_BEEF never presented; next imem_addr_o = 0x0000_0100.
- Redirect coincident with request handshake at addr 0x10 → state DROP; 0x10's response dropped; next request at redirect target.
- HOLD with if_ready_i=0 for 4 cycles → if_valid_o=1 and if_pc_o/if_instr_o constant; no new imem request; request issues the cycle after if_ready_i rises.
- rst_n pulsed low during WAIT at pc 0x20 → if_valid_o=0 and imem_req_valid_o=0 immediately; after release, addr restarts at RESET_PC; a stale response is ignored.
